// File: rtl/reg_file_wb.sv
// 16-entry 2R/1W register file with a one-deep write-back buffer and read bypass.
// Writes commit on the edge after capture; reads are combinational and see the buffered write.
module reg_file_wb #(
  parameter int WIDTH   = 8,
  parameter int ZERO_R0 = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RW,
  input  logic [3:0]       DA,
  input  logic [WIDTH-1:0] D_in,
  input  logic [3:0]       AA,
  input  logic [3:0]       BA,
  output logic [WIDTH-1:0] A_data,
  output logic [WIDTH-1:0] B_data,
  output logic             wb_pending,
  output logic [CNT_W-1:0] wr_count
);

  logic [WIDTH-1:0] mem_q [16];
  logic [WIDTH-1:0] mem_d [16];
  logic             wb_vld_q, wb_vld_d;
  logic [3:0]       wb_addr_q, wb_addr_d;
  logic [WIDTH-1:0] wb_dat_q, wb_dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drop_r0;

  assign drop_r0 = (ZERO_R0 != 0) && (DA == 4'd0);

  // Old buffer commits on the same edge that captures the new request.
  always_comb begin
    mem_d     = mem_q;
    cnt_d     = cnt_q;
    wb_vld_d  = RW && !drop_r0;
    wb_addr_d = wb_addr_q;
    wb_dat_d  = wb_dat_q;
    if (RW) begin
      wb_addr_d = DA;
      wb_dat_d  = D_in;
    end
    if (wb_vld_q) begin
      mem_d[wb_addr_q] = wb_dat_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem_q[i] <= '0;
      wb_vld_q  <= 1'b0;
      wb_addr_q <= '0;
      wb_dat_q  <= '0;
      cnt_q     <= '0;
    end else begin
      mem_q     <= mem_d;
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      wb_dat_q  <= wb_dat_d;
      cnt_q     <= cnt_d;
    end
  end

  // R0 hardwiring takes priority over the bypass.
  always_comb begin
    A_data = mem_q[AA];
    if (wb_vld_q && (wb_addr_q == AA)) A_data = wb_dat_q;
    if ((ZERO_R0 != 0) && (AA == 4'd0)) A_data = '0;
    B_data = mem_q[BA];
    if (wb_vld_q && (wb_addr_q == BA)) B_data = wb_dat_q;
    if ((ZERO_R0 != 0) && (BA == 4'd0)) B_data = '0;
  end

  assign wb_pending = wb_vld_q;
  assign wr_count   = cnt_q;

endmodule
